alu_arbiter: RTL and testbench

- Controller that shares one ALU datapath instance between two requesters (port 0 and port 1).
- Performs round-robin arbitration, latches the operands and control code, and drives the ALU for the required number of cycles.
- Captures the result and n,z,c,v flags into a registered response returned with a requester id over a valid/ready handshake.
- Sits between the issue logic and the shared ALU; the multiply op gets a configurable multi-cycle settle window.

---
 rtl/alu_arbiter_if.sv | 45 ++++
 rtl/alu_arbiter.sv | 109 ++++++++++
 tb/tb_alu_arbiter.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/alu_arbiter_if.sv
// Handshake and ALU bundle between two requesters, one consumer and the shared ALU.
// slave: arbiter side; master: requesters, consumer and ALU side.
interface alu_arbiter_if #(
  parameter int WIDTH = 32
);
  logic             req0_valid;
  logic             req0_ready;
  logic [WIDTH-1:0] req0_a;
  logic [WIDTH-1:0] req0_b;
  logic [3:0]       req0_op;
  logic             req1_valid;
  logic             req1_ready;
  logic [WIDTH-1:0] req1_a;
  logic [WIDTH-1:0] req1_b;
  logic [3:0]       req1_op;
  logic             rsp_valid;
  logic             rsp_ready;
  logic             rsp_id;
  logic [WIDTH-1:0] rsp_result;
  logic [3:0]       rsp_flags;
  logic             busy;
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [3:0]       alu_control;
  logic [WIDTH-1:0] alu_result;
  logic [3:0]       alu_flags;

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_op,
    input  req1_valid, req1_a, req1_b, req1_op,
    input  rsp_ready, alu_result, alu_flags,
    output req0_ready, req1_ready,
    output rsp_valid, rsp_id, rsp_result, rsp_flags,
    output busy, alu_a, alu_b, alu_control
  );

  modport master (
    output req0_valid, req0_a, req0_b, req0_op,
    output req1_valid, req1_a, req1_b, req1_op,
    output rsp_ready, alu_result, alu_flags,
    input  req0_ready, req1_ready,
    input  rsp_valid, rsp_id, rsp_result, rsp_flags,
    input  busy, alu_a, alu_b, alu_control
  );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin sharing of one ALU between two requesters, registered response.
// Ports: clk, rst_n (sync, active-low), bus (alu_arbiter_if.slave).
module alu_arbiter #(
  parameter int WIDTH      = 32,
  parameter int MUL_CYCLES = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  alu_arbiter_if.slave  bus
);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
  localparam logic [3:0] OP_MUL = 4'b0110;
  localparam logic [3:0] OP_NOP = 4'b0000;
  localparam logic [3:0] MUL_LD = 4'(MUL_CYCLES - 1);

  logic [1:0]       r_state;
  logic             r_last;
  logic             r_id;
  logic [3:0]       r_cnt;
  logic [WIDTH-1:0] r_alu_a;
  logic [WIDTH-1:0] r_alu_b;
  logic [3:0]       r_alu_op;
  logic             r_rsp_valid;
  logic             r_rsp_id;
  logic [WIDTH-1:0] r_rsp_result;
  logic [3:0]       r_rsp_flags;

  logic             w_idle;
  logic             w_any;
  logic             w_gid;
  logic [WIDTH-1:0] w_a;
  logic [WIDTH-1:0] w_b;
  logic [3:0]       w_op;

  // Contested cycles go to the port that did not win last time.
  assign w_idle = (r_state == S_IDLE);
  assign w_any  = bus.req0_valid | bus.req1_valid;
  assign w_gid  = (bus.req0_valid & bus.req1_valid)
                ? ~r_last : bus.req1_valid;
  assign w_a    = w_gid ? bus.req1_a  : bus.req0_a;
  assign w_b    = w_gid ? bus.req1_b  : bus.req0_b;
  assign w_op   = w_gid ? bus.req1_op : bus.req0_op;

  assign bus.req0_ready  = w_idle & w_any & ~w_gid;
  assign bus.req1_ready  = w_idle & w_any & w_gid;
  assign bus.busy        = ~w_idle;
  assign bus.alu_a       = r_alu_a;
  assign bus.alu_b       = r_alu_b;
  assign bus.alu_control = r_alu_op;
  assign bus.rsp_valid   = r_rsp_valid;
  assign bus.rsp_id      = r_rsp_id;
  assign bus.rsp_result  = r_rsp_result;
  assign bus.rsp_flags   = r_rsp_flags;

  // ALU input registers double as the operand latch: loaded
  // at accept, cleared at capture, so they are 0 outside EXEC.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_last       <= 1'b1;
      r_id         <= 1'b0;
      r_cnt        <= '0;
      r_alu_a      <= '0;
      r_alu_b      <= '0;
      r_alu_op     <= OP_NOP;
      r_rsp_valid  <= 1'b0;
      r_rsp_id     <= 1'b0;
      r_rsp_result <= '0;
      r_rsp_flags  <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_alu_a  <= w_a;
            r_alu_b  <= w_b;
            r_alu_op <= w_op;
            r_id     <= w_gid;
            r_last   <= w_gid;
            r_cnt    <= (w_op == OP_MUL) ? MUL_LD : 4'd0;
            r_state  <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (r_cnt == 4'd0) begin
            r_rsp_result <= bus.alu_result;
            r_rsp_flags  <= bus.alu_flags;
            r_rsp_id     <= r_id;
            r_rsp_valid  <= 1'b1;
            r_alu_a      <= '0;
            r_alu_b      <= '0;
            r_alu_op     <= OP_NOP;
            r_state      <= S_DONE;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        S_DONE: begin
          if (bus.rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_arbiter.sv
// Directed and random bench for alu_arbiter with a behavioural ALU and arbiter model.
// Instantiates the interface, the DUT (MUL_CYCLES=3) and drives every port.
module tb_alu_arbiter;
  localparam int W    = 32;
  localparam int MULC = 3;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks   = 0;
  int   failures = 0;
  logic model_last;

  always #5 clk = ~clk;

  alu_arbiter_if #(.WIDTH(W)) bus ();

  alu_arbiter #(
    .WIDTH(W),
    .MUL_CYCLES(MULC)
  ) u_dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  function automatic logic [31:0] ref_res(
    logic [31:0] a, logic [31:0] b, logic [3:0] op);
    logic [31:0] r;
    casez (op)
      4'b0000: r = a & b;
      4'b0001: r = a - b;
      4'b0010: r = a + b;
      4'b0011: r = a | b;
      4'b0100: r = a ^ b;
      4'b0101: r = (a < b) ? 32'd1 : 32'd0;
      4'b0110: r = a * b;
      4'b0111: r = a << b[4:0];
      default: r = a >> b[4:0];
    endcase
    return r;
  endfunction

  function automatic logic [3:0] ref_flags(
    logic [31:0] a, logic [31:0] b, logic [3:0] op);
    logic [31:0] r;
    logic [32:0] s;
    logic        c;
    logic        v;
    r = ref_res(a, b, op);
    s = {1'b0, a} + {1'b0, b};
    c = 1'b0;
    v = 1'b0;
    if (op == 4'b0010) begin
      c = s[32];
      v = (a[31] == b[31]) && (r[31] != a[31]);
    end else if (op == 4'b0001) begin
      c = (a >= b);
      v = (a[31] != b[31]) && (r[31] != a[31]);
    end
    return {r[31], r == 32'd0, c, v};
  endfunction

  assign bus.alu_result = ref_res(bus.alu_a, bus.alu_b, bus.alu_control);
  assign bus.alu_flags  = ref_flags(bus.alu_a, bus.alu_b, bus.alu_control);

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(
    bit v0, bit v1,
    logic [31:0] a0, logic [31:0] b0, logic [3:0] op0,
    logic [31:0] a1, logic [31:0] b1, logic [3:0] op1,
    int hold);
    bit          gid;
    logic [31:0] ea;
    logic [31:0] eb;
    logic [3:0]  eop;
    logic [31:0] eres;
    logic [3:0]  efl;
    int          lat;
    int          elat;
    gid = (v0 && v1) ? ~model_last : v1;
    ea  = gid ? a1 : a0;
    eb  = gid ? b1 : b0;
    eop = gid ? op1 : op0;
    eres = ref_res(ea, eb, eop);
    efl  = ref_flags(ea, eb, eop);
    elat = (eop == 4'b0110) ? MULC : 1;
    bus.req0_valid = v0;
    bus.req0_a = a0;
    bus.req0_b = b0;
    bus.req0_op = op0;
    bus.req1_valid = v1;
    bus.req1_a = a1;
    bus.req1_b = b1;
    bus.req1_op = op1;
    #1;
    chk("ready0", 32'(bus.req0_ready), 32'(v0 && !gid));
    chk("ready1", 32'(bus.req1_ready), 32'(v1 && gid));
    tick();
    model_last = gid;
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    bus.req0_a = $urandom;
    bus.req1_a = $urandom;
    bus.req0_op = 4'($urandom);
    chk("busy_exec", 32'(bus.busy), 32'd1);
    lat = 0;
    while (!bus.rsp_valid && lat < 40) begin
      chk("alu_ctl_hold", 32'(bus.alu_control), 32'(eop));
      chk("alu_a_hold", bus.alu_a, ea);
      tick();
      lat++;
    end
    chk("latency", 32'(lat), 32'(elat));
    chk("rsp_id", 32'(bus.rsp_id), 32'(gid));
    chk("rsp_result", bus.rsp_result, eres);
    chk("rsp_flags", 32'(bus.rsp_flags), 32'(efl));
    chk("alu_ctl_done", 32'(bus.alu_control), 32'd0);
    for (int i = 0; i < hold; i++) begin
      bus.req0_valid = 1'b1;
      bus.req1_valid = 1'b1;
      bus.req0_a = $urandom;
      bus.req1_b = $urandom;
      #1;
      chk("bp_ready0", 32'(bus.req0_ready), 32'd0);
      chk("bp_ready1", 32'(bus.req1_ready), 32'd0);
      chk("bp_busy", 32'(bus.busy), 32'd1);
      chk("bp_valid", 32'(bus.rsp_valid), 32'd1);
      chk("bp_result", bus.rsp_result, eres);
      chk("bp_id", 32'(bus.rsp_id), 32'(gid));
      tick();
    end
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    chk("rel_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rel_busy", 32'(bus.busy), 32'd0);
  endtask

  initial begin
    bus.req0_valid = 1'b0;
    bus.req0_a = '0;
    bus.req0_b = '0;
    bus.req0_op = '0;
    bus.req1_valid = 1'b0;
    bus.req1_a = '0;
    bus.req1_b = '0;
    bus.req1_op = '0;
    bus.rsp_ready = 1'b0;
    model_last = 1'b1;
    rst_n = 1'b0;
    tick();
    tick();
    chk("rst_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_id", 32'(bus.rsp_id), 32'd0);
    chk("rst_result", bus.rsp_result, 32'd0);
    chk("rst_flags", 32'(bus.rsp_flags), 32'd0);
    chk("rst_alu_a", bus.alu_a, 32'd0);
    chk("rst_alu_b", bus.alu_b, 32'd0);
    chk("rst_alu_ctl", 32'(bus.alu_control), 32'd0);
    chk("rst_ready0", 32'(bus.req0_ready), 32'd0);
    chk("rst_ready1", 32'(bus.req1_ready), 32'd0);
    rst_n = 1'b1;
    tick();

    run_op(1, 1, 32'd7, 32'd7, 4'b0001, 32'hF0, 32'h0F, 4'b0011, 0);
    chk("first_win_port0", 32'(model_last), 32'd0);
    run_op(1, 1, 32'd7, 32'd7, 4'b0001, 32'hF0, 32'h0F, 4'b0011, 0);
    for (int i = 0; i < 4; i++)
      run_op(1, 1, $urandom, $urandom, 4'b0010,
             $urandom, $urandom, 4'b0100, 0);

    run_op(1, 0, 32'd5, 32'd3, 4'b0010, 32'd0, 32'd0, 4'b0000, 0);
    run_op(0, 1, 32'd0, 32'd0, 4'b0000, 32'd6, 32'd7, 4'b0110, 5);
    run_op(1, 0, 32'h80, 32'd4, 4'b1101, 32'd0, 32'd0, 4'b0000, 0);

    bus.req1_valid = 1'b1;
    bus.req1_a = 32'd6;
    bus.req1_b = 32'd7;
    bus.req1_op = 4'b0110;
    tick();
    bus.req1_valid = 1'b0;
    tick();
    chk("pre_rst_busy", 32'(bus.busy), 32'd1);
    rst_n = 1'b0;
    tick();
    model_last = 1'b1;
    chk("mid_rst_valid", 32'(bus.rsp_valid), 32'd0);
    chk("mid_rst_busy", 32'(bus.busy), 32'd0);
    chk("mid_rst_ctl", 32'(bus.alu_control), 32'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("dropped_no_rsp", 32'(bus.rsp_valid), 32'd0);
    end
    run_op(1, 1, 32'd9, 32'd1, 4'b0001, 32'd2, 32'd3, 4'b0010, 0);
    chk("post_rst_port0", 32'(model_last), 32'd0);

    for (int i = 0; i < 20; i++) begin
      bit v0;
      bit v1;
      v0 = 1'($urandom_range(0, 1));
      v1 = v0 ? 1'($urandom_range(0, 1)) : 1'b1;
      run_op(v0, v1, $urandom, $urandom, 4'($urandom),
             $urandom, $urandom, 4'($urandom),
             int'($urandom_range(0, 3)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
